// File: rtl/cpu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_bus_sequencer
//
// Generates the two CPU phase enables from a free-running clk divider and
// sequences one bus cycle per address strobe: address phase, wait for the
// external acknowledge (with a bus-error timeout), data phase and bus-error
// termination. Everything runs on clk; the phase enables gate when the FSM
// is allowed to move.
//
// Parameters
//   DIV       clk cycles per CPU half-period (>= 1)
//   OE_DELAY  phi1 strobes from ADDR entry until write-OE and WAIT (>= 0)
//   TIMEOUT   phi2 strobes spent in WAIT before a bus error (>= 1)
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   hold_n       active-low DMA hold; freezes the phase counter and strobes
//   as_n, rw_n   core address strobe / read-write (write when low)
//   dtack_n      external data acknowledge, active low
//   phi1_ce      one-clk enable at phase count 0
//   phi2_ce      one-clk enable at phase count DIV
//   cpu_dtack_n  acknowledge to the core, low while in DATA
//   berr_n       bus error to the core, low while in TERM
//   oe           write data bus drive enable
//   cycle_state  IDLE=0, ADDR=1, WAIT=2, DATA=3, TERM=4
// ---------------------------------------------------------------------------
module cpu_bus_sequencer #(
    parameter int DIV      = 2,
    parameter int OE_DELAY = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hold_n,
    input  logic       as_n,
    input  logic       rw_n,
    input  logic       dtack_n,
    output logic       phi1_ce,
    output logic       phi2_ce,
    output logic       cpu_dtack_n,
    output logic       berr_n,
    output logic       oe,
    output logic [2:0] cycle_state
);

    localparam int PH_W = (2 * DIV > 2) ? $clog2(2 * DIV) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Keep the OE-delay counter at least one bit wide even for OE_DELAY=0.
    localparam int OD_W = (OE_DELAY < 1) ? 1 : $clog2(OE_DELAY + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [OD_W-1:0] OD_MAX  = OD_W'(OE_DELAY);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_TERM = 3'd4;

    logic [PH_W-1:0] r_ph;
    logic [2:0]      r_state;
    logic            r_oe;
    logic [TO_W-1:0] r_to_cnt;
    logic [OD_W-1:0] r_od_cnt;

    logic            w_phi1;
    logic            w_phi2;
    logic            w_abort;
    logic [TO_W-1:0] w_to_inc;
    logic [OD_W-1:0] w_od_next;
    logic            w_od_done;

    // Strobes are gated by reset_n because the counter sits at 0 in reset,
    // which would otherwise present phi1_ce while reset is held.
    assign w_phi1 = reset_n & hold_n & (r_ph == '0);
    assign w_phi2 = reset_n & hold_n & (r_ph == PH_HALF);

    // An address strobe released on a phi1 edge ends whatever cycle is open.
    assign w_abort = w_phi1 & as_n;

    // Both counters saturate so a long stall can never wrap them.
    assign w_to_inc  = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + TO_W'(1);
    assign w_od_next = (w_phi1 && (r_od_cnt != OD_MAX)) ? r_od_cnt + OD_W'(1)
                                                        : r_od_cnt;
    assign w_od_done = (w_od_next >= OD_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph <= '0;
        end else if (hold_n) begin
            r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_oe     <= 1'b0;
            r_to_cnt <= '0;
            r_od_cnt <= '0;
        end else if (w_phi1 || w_phi2) begin
            case (r_state)
                S_IDLE: begin
                    if (w_phi1 && !as_n) begin
                        r_state  <= S_ADDR;
                        r_to_cnt <= '0;
                        r_od_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_oe     <= 1'b0;
                        r_to_cnt <= '0;
                        r_od_cnt <= '0;
                    end else begin
                        r_od_cnt <= w_od_next;
                        if (w_od_done) begin
                            r_oe    <= ~rw_n;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_oe     <= 1'b0;
                        r_to_cnt <= '0;
                        r_od_cnt <= '0;
                    end else if (w_phi2) begin
                        // Acknowledge wins over a timeout on the same strobe.
                        if (!dtack_n) begin
                            r_state <= S_DATA;
                        end else begin
                            r_to_cnt <= w_to_inc;
                            if (w_to_inc == TO_MAX) begin
                                r_state <= S_TERM;
                                r_oe    <= 1'b0;
                            end
                        end
                    end
                end
                S_DATA, S_TERM: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    assign phi1_ce     = w_phi1;
    assign phi2_ce     = w_phi2;
    assign cpu_dtack_n = (r_state != S_DATA);
    assign berr_n      = (r_state != S_TERM);
    // DMA owns the bus during hold; the registered enable returns afterwards.
    assign oe          = r_oe & hold_n;
    assign cycle_state = r_state;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_sequencer
//
// Directed stimulus with hand-written expected output vectors per clk slot.
// The stimulus process queues the expected {phi1_ce, phi2_ce, oe,
// cpu_dtack_n, berr_n, cycle_state} for each slot; the monitor pops and
// compares on every falling edge. DIV=2, OE_DELAY=1, TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_cpu_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold_n = 1'b1;
    logic       as_n = 1'b1;
    logic       rw_n = 1'b1;
    logic       dtack_n = 1'b1;
    logic       phi1_ce;
    logic       phi2_ce;
    logic       cpu_dtack_n;
    logic       berr_n;
    logic       oe;
    logic [2:0] cycle_state;

    cpu_bus_sequencer #(
        .DIV      (2),
        .OE_DELAY (1),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hold_n      (hold_n),
        .as_n        (as_n),
        .rw_n        (rw_n),
        .dtack_n     (dtack_n),
        .phi1_ce     (phi1_ce),
        .phi2_ce     (phi2_ce),
        .cpu_dtack_n (cpu_dtack_n),
        .berr_n      (berr_n),
        .oe          (oe),
        .cycle_state (cycle_state)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] mon_got;
    logic [7:0] mon_want;
    int         n_chk = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    string      tag = "reset";
    int         ph = 0;      // expected phase count for the next slot

    // Monitor: one comparison per slot.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_got = {phi1_ce, phi2_ce, oe, cpu_dtack_n, berr_n, cycle_state};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: no expected entry queued, got=%b", tag, mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    n_err++;
                    $display("FAIL %s @%0t: {p1,p2,oe,cdtack_n,berr_n,state} got=%b required=%b",
                             tag, $time, mon_got, mon_want);
                end
            end
        end
    end

    // One slot with reset asserted mid-cycle (2 time units after the edge).
    task automatic rst_slot();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        as_n    = 1'b1;
        rw_n    = 1'b1;
        dtack_n = 1'b1;
        hold_n  = 1'b1;
        exp_q.push_back(8'b0001_1000);
        mon_en  = 1'b1;
        ph      = 0;
    endtask

    // n slots with fixed inputs; state-side outputs are given by hand, the
    // strobes follow the bench's own phase count (phi1 at 0, phi2 at 2).
    task automatic cyc(input int n, input logic a, input logic r, input logic d,
                       input logic h, input logic e_oe, input logic e_cdt,
                       input logic e_berr, input logic [2:0] e_st);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            as_n    = a;
            rw_n    = r;
            dtack_n = d;
            hold_n  = h;
            exp_q.push_back({h && (ph == 0), h && (ph == 2), e_oe, e_cdt, e_berr, e_st});
            if (h) ph = (ph + 1) % 4;
        end
    endtask

    initial begin
        tag = "reset";
        rst_slot();
        rst_slot();

        // Free run: phi1 every 4 clk, phi2 two clk later; first phi1 at once.
        tag = "free-run";
        cyc(8, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        // Write with dtack low from the start.
        tag = "write";
        cyc(1, 0, 0, 0, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 0, 0, 1, 0, 1, 1, 3'd1);
        cyc(2, 0, 0, 0, 1, 1, 1, 1, 3'd2);
        cyc(1, 0, 0, 0, 1, 1, 0, 1, 3'd3);
        cyc(1, 1, 0, 0, 1, 1, 0, 1, 3'd3);
        cyc(3, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        // Read with dtack never arriving: 4 phi2 in WAIT then TERM.
        tag = "read-timeout";
        cyc(1, 0, 1, 1, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 1, 1, 1, 0, 1, 1, 3'd1);
        cyc(14, 0, 1, 1, 1, 0, 1, 1, 3'd2);
        cyc(1, 0, 1, 1, 1, 0, 1, 0, 3'd4);
        cyc(1, 1, 1, 1, 1, 0, 1, 0, 3'd4);
        cyc(3, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        // Write where dtack arrives on the 4th WAIT phi2: DATA, not TERM.
        tag = "dtack-at-limit";
        cyc(1, 0, 0, 1, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 0, 1, 1, 0, 1, 1, 3'd1);
        cyc(13, 0, 0, 1, 1, 1, 1, 1, 3'd2);
        cyc(1, 0, 0, 0, 1, 1, 1, 1, 3'd2);
        cyc(1, 0, 0, 0, 1, 1, 0, 1, 3'd3);
        cyc(1, 0, 0, 0, 1, 1, 0, 1, 3'd3);

        // Reset pulsed while in DATA: outputs must drop before any edge.
        tag = "reset-in-data";
        rst_slot();
        rst_slot();

        // Write stalled in WAIT, hold for 10 clk at a phi1 phase, then resume.
        tag = "hold";
        cyc(1, 0, 0, 1, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 0, 1, 1, 0, 1, 1, 3'd1);
        cyc(3, 0, 0, 1, 1, 1, 1, 1, 3'd2);
        cyc(10, 0, 0, 1, 0, 0, 1, 1, 3'd2);
        cyc(11, 0, 0, 1, 1, 1, 1, 1, 3'd2);
        cyc(1, 0, 0, 1, 1, 0, 1, 0, 3'd4);
        cyc(1, 1, 1, 1, 1, 0, 1, 0, 3'd4);
        cyc(3, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        // Write aborted in WAIT by as_n rising on phi1.
        tag = "abort";
        cyc(1, 0, 0, 1, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 0, 1, 1, 0, 1, 1, 3'd1);
        cyc(3, 0, 0, 1, 1, 1, 1, 1, 3'd2);
        cyc(1, 1, 0, 1, 1, 1, 1, 1, 3'd2);
        cyc(3, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        // Full timeout again after the abort: counters start from zero.
        tag = "read-after-abort";
        cyc(1, 0, 1, 1, 1, 0, 1, 1, 3'd0);
        cyc(4, 0, 1, 1, 1, 0, 1, 1, 3'd1);
        cyc(14, 0, 1, 1, 1, 0, 1, 1, 3'd2);
        cyc(1, 0, 1, 1, 1, 0, 1, 0, 3'd4);
        cyc(1, 1, 1, 1, 1, 0, 1, 0, 3'd4);
        cyc(2, 1, 1, 1, 1, 0, 1, 1, 3'd0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_bus_sequencer.md
CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 2, meaning clk cycles per CPU half-period (DIV>=1).
REQ-002 The block SHALL have parameter OE_DELAY, default 1, meaning phi1 strobes from ADDR entry to write-OE assertion (OE_DELAY>=0).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning phi2 strobes in WAIT before bus error (TIMEOUT>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock; every register SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port hold_n, input, 1 bit: active-low DMA hold; 0 freezes the CPU.
REQ-007 The block SHALL have ports as_n and rw_n, inputs, 1 bit each: core address strobe and read/write (write when low).
REQ-008 The block SHALL have port dtack_n, input, 1 bit: external data acknowledge, active low.
REQ-009 The block SHALL have ports phi1_ce and phi2_ce, outputs, 1 bit each: single-clk CPU phase enables.
REQ-010 The block SHALL have port cpu_dtack_n, output, 1 bit: acknowledge to the core, active low.
REQ-011 The block SHALL have ports berr_n, output, 1 bit (bus error to the core, active low), and oe, output, 1 bit (write data bus drive enable).
REQ-012 The block SHALL have port cycle_state, output, 3 bits: IDLE=0, ADDR=1, WAIT=2, DATA=3, TERM=4.

Function
REQ-013 The phase counter SHALL count 0..2*DIV-1 and wrap to 0.
REQ-014 phi1_ce SHALL be 1 for exactly the clk cycle in which the count is 0; phi2_ce SHALL be 1 for exactly the clk cycle in which the count is DIV.
REQ-015 While hold_n=0, the counter SHALL hold its value and phi1_ce/phi2_ce SHALL be 0; counting SHALL resume from the held value on the first clk after hold_n returns to 1.
REQ-016 FSM transitions SHALL occur only on clk edges on which phi1_ce or phi2_ce is 1; the strobe named in each transition below is the one that enables it.
REQ-017 IDLE->ADDR SHALL occur on phi1_ce with as_n=0; entering ADDR SHALL clear the timeout and OE-delay counters.
REQ-018 ADDR: each phi1_ce SHALL increment the OE-delay count; when the count reaches OE_DELAY (immediately on entry if OE_DELAY=0), oe SHALL be set to ~rw_n and the FSM SHALL move to WAIT.
REQ-019 WAIT: on phi2_ce with dtack_n=0, the FSM SHALL move to DATA; otherwise the timeout count SHALL increment.
REQ-020 WAIT: when the timeout count reaches TIMEOUT, the FSM SHALL move to TERM in the same cycle.
REQ-021 If dtack_n=0 coincides with the TIMEOUT-th strobe, the FSM SHALL take DATA.
REQ-022 cpu_dtack_n SHALL be 0 exactly while in DATA, and 1 in all other states.
REQ-023 berr_n SHALL be 0 exactly while in TERM, and 1 in all other states.
REQ-024 DATA and TERM SHALL return to IDLE on phi1_ce with as_n=1.
REQ-025 oe SHALL clear on entering IDLE or TERM.
REQ-026 If as_n=1 on phi1_ce in ADDR or WAIT (aborted cycle), the FSM SHALL return to IDLE, clear oe and clear both counters.
REQ-027 oe SHALL be forced to 0 while hold_n=0, and SHALL restore to its registered value when hold_n returns to 1.
REQ-028 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrapping.

Reset
REQ-029 While reset_n=0, the block SHALL hold: counter=0, FSM=IDLE, phi1_ce=0, phi2_ce=0, cpu_dtack_n=1, berr_n=1, oe=0, cycle_state=0.
REQ-030 Reset asserted mid-cycle SHALL abort the cycle immediately, without waiting for a clock edge.
REQ-031 After reset_n deasserts, the first phi1_ce SHALL occur on the first clk edge.

Verification (DIV=2, OE_DELAY=1, TIMEOUT=4)
REQ-032 Free-run, hold_n=1 -> phi1_ce every 4 clk; phi2_ce 2 clk after each phi1_ce; neither strobe ever coincides.
REQ-033 Write (as_n=0, rw_n=0), dtack_n=0 from the start -> cycle_state 1,2,3; oe=1 from the 2nd phi1_ce; cpu_dtack_n=0 in DATA; as_n=1 -> IDLE, oe=0.
REQ-034 Read with dtack_n held 1 -> 4 phi2_ce in WAIT, then TERM, berr_n=0, oe=0; as_n=1 -> IDLE, berr_n=1.
REQ-035 hold_n=0 for 10 clk in WAIT -> no strobes, oe=0, timeout count frozen; on hold_n=1 -> phase and count resume unchanged.
REQ-036 reset_n pulsed low in DATA -> all outputs at reset values immediately, cycle_state=0.
REQ-037 dtack_n=0 on the 4th WAIT phi2_ce -> DATA, berr_n stays 1.
